// File: rtl/scr_shuffle_pkg.sv
`default_nettype none
// ============================================================================
// Module      : scr_shuffle_pkg
// Description : Shared types and constants for the loop-shuffling permutation
//               sequencer: FSM state encoding, LFSR constants and the
//               bound-mask helper used by the Fisher-Yates draw.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package scr_shuffle_pkg;

    // Sequencer states. Explicit 2-bit encoding so the state register width
    // is fixed regardless of tool defaults.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_INIT    = 2'd1,
        ST_SHUFFLE = 2'd2,
        ST_SERVE   = 2'd3
    } state_t;

    // Galois feedback mask and fallback seed for the 16-bit LFSR.
    localparam logic [15:0] LFSR_TAPS    = 16'hB400;
    localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

    // Smallest all-ones value >= i. Smearing the highest set bit downwards
    // turns i into 2**m-1 with 2**(m-1) <= i, which is exactly the bound
    // mask for the rejection-sampling draw. mask_for(0) is 0.
    function automatic logic [15:0] mask_for(input logic [15:0] i);
        logic [15:0] m;
        m = i;
        m = m | (m >> 1);
        m = m | (m >> 2);
        m = m | (m >> 4);
        m = m | (m >> 8);
        return m;
    endfunction

endpackage
`default_nettype wire

// File: rtl/scr_shuffle_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : scr_shuffle_ctrl_if
// Description : Bus bundle between the hwlp/controller side and the shuffle
//               sequencer, plus the index consumer side.
// Signals     : start_i        - start pulse (latches N and seed)
//               num_elements_i - loop trip count N
//               seed_i         - LFSR seed (0 selects the default seed)
//               abort_i        - cancel the current permutation
//               iter_req_i     - next-index request
//               iter_ack_o     - one-cycle ack, index_o valid with it
//               index_o        - permuted iteration index
//               ready_o        - table shuffled, requests accepted
//               busy_o         - filling or shuffling the table
//               done_o         - last index served
//               err_o          - illegal N on start
// Modports    : master - controller / bench side
//               slave  - sequencer side
// Revision    : 1.0 - initial release
// ============================================================================
interface scr_shuffle_ctrl_if #(
    parameter int BITS_PER_ELEMENT = 7
);
    logic                        start_i;
    logic [BITS_PER_ELEMENT:0]   num_elements_i;
    logic [15:0]                 seed_i;
    logic                        abort_i;
    logic                        iter_req_i;
    logic                        iter_ack_o;
    logic [BITS_PER_ELEMENT-1:0] index_o;
    logic                        ready_o;
    logic                        busy_o;
    logic                        done_o;
    logic                        err_o;

    modport master (
        output start_i,
        output num_elements_i,
        output seed_i,
        output abort_i,
        output iter_req_i,
        input  iter_ack_o,
        input  index_o,
        input  ready_o,
        input  busy_o,
        input  done_o,
        input  err_o
    );

    modport slave (
        input  start_i,
        input  num_elements_i,
        input  seed_i,
        input  abort_i,
        input  iter_req_i,
        output iter_ack_o,
        output index_o,
        output ready_o,
        output busy_o,
        output done_o,
        output err_o
    );
endinterface
`default_nettype wire

// File: rtl/scr_lfsr16.sv
`default_nettype none
// ============================================================================
// Module      : scr_lfsr16
// Description : 16-bit Galois LFSR, right-shifting. When the bit shifted out
//               is 1 the shifted value is XORed with TAPS. Load has priority
//               over advance.
// Ports       : clk      - clock
//               rst      - asynchronous active-low reset (value = RESET_VALUE)
//               load_i   - load seed_i this cycle
//               seed_i   - value to load
//               en_i     - advance one step this cycle
//               value_o  - current LFSR state
// Revision    : 1.0 - initial release
// ============================================================================
module scr_lfsr16
    import scr_shuffle_pkg::*;
#(
    parameter logic [15:0] TAPS        = LFSR_TAPS,
    parameter logic [15:0] RESET_VALUE = DEFAULT_SEED
) (
    input  wire logic        clk,
    input  wire logic        rst,
    input  wire logic        load_i,
    input  wire logic [15:0] seed_i,
    input  wire logic        en_i,
    output logic      [15:0] value_o
);

    logic [15:0] r_value;
    logic [15:0] w_step;

    assign w_step = r_value[0] ? ((r_value >> 1) ^ TAPS) : (r_value >> 1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_value <= RESET_VALUE;
        end else if (load_i) begin
            r_value <= seed_i;
        end else if (en_i) begin
            r_value <= w_step;
        end
    end

    assign value_o = r_value;

endmodule
`default_nettype wire

// File: rtl/scr_shuffle_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : scr_shuffle_ctrl
// Description : Loop-shuffling permutation sequencer. On start it fills a
//               table with 0..N-1, shuffles it in place with Fisher-Yates
//               (LFSR-driven rejection sampling), then hands out one permuted
//               index per hardware-loop iteration request.
// Ports       : clk - clock
//               rst - asynchronous active-low reset
//               bus - scr_shuffle_ctrl_if.slave:
//                     start_i/num_elements_i/seed_i  start a permutation
//                     abort_i                        cancel, return to idle
//                     iter_req_i -> iter_ack_o/index_o  index handshake
//                     ready_o/busy_o/done_o/err_o    status
// Revision    : 1.0 - initial release
// ============================================================================
module scr_shuffle_ctrl #(
    parameter int          BITS_PER_ELEMENT = 7,
    parameter logic [15:0] LFSR_TAPS        = scr_shuffle_pkg::LFSR_TAPS,
    parameter logic [15:0] DEFAULT_SEED     = scr_shuffle_pkg::DEFAULT_SEED
) (
    input  wire logic         clk,
    input  wire logic         rst,
    scr_shuffle_ctrl_if.slave bus
);

    import scr_shuffle_pkg::*;

    localparam int                        C_DEPTH_INT = 1 << BITS_PER_ELEMENT;
    localparam logic [BITS_PER_ELEMENT:0] C_DEPTH     = {1'b1, {BITS_PER_ELEMENT{1'b0}}};
    localparam logic [BITS_PER_ELEMENT:0] C_ONE       = (BITS_PER_ELEMENT+1)'(1);

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    state_t                        r_state;
    logic [BITS_PER_ELEMENT:0]     r_n;      // latched trip count
    logic [BITS_PER_ELEMENT:0]     r_k;      // fill pointer during INIT
    logic [BITS_PER_ELEMENT:0]     r_i;      // Fisher-Yates position
    logic [BITS_PER_ELEMENT:0]     r_c;      // served count during SERVE
    logic [BITS_PER_ELEMENT-1:0]   r_index;  // last served index (held)
    logic [BITS_PER_ELEMENT-1:0]   r_table [0:C_DEPTH_INT-1];

    // ------------------------------------------------------------------
    // Combinational signals
    // ------------------------------------------------------------------
    state_t                        w_state_nxt;
    logic [BITS_PER_ELEMENT:0]     w_n_nxt;
    logic [BITS_PER_ELEMENT:0]     w_k_nxt;
    logic [BITS_PER_ELEMENT:0]     w_i_nxt;
    logic [BITS_PER_ELEMENT:0]     w_c_nxt;
    logic [BITS_PER_ELEMENT:0]     w_n_m1;
    logic                          w_n_legal;
    logic [15:0]                   w_seed;
    logic [15:0]                   w_lfsr;
    logic                          w_lfsr_load;
    logic                          w_lfsr_en;
    logic [BITS_PER_ELEMENT-1:0]   w_r;
    logic [BITS_PER_ELEMENT:0]     w_r_ext;
    logic [BITS_PER_ELEMENT-1:0]   w_k_idx;
    logic [BITS_PER_ELEMENT-1:0]   w_i_idx;
    logic [BITS_PER_ELEMENT-1:0]   w_c_idx;
    logic [BITS_PER_ELEMENT-1:0]   w_rd_data;
    logic                          w_init_wr;
    logic                          w_swap;
    logic                          w_ack;
    logic                          w_done;
    logic                          w_err;

    // ------------------------------------------------------------------
    // Random source
    // ------------------------------------------------------------------
    // A zero seed would lock a Galois LFSR at zero, so it selects the
    // default seed instead.
    assign w_seed = (bus.seed_i == 16'h0000) ? DEFAULT_SEED : bus.seed_i;

    scr_lfsr16 #(
        .TAPS        (LFSR_TAPS),
        .RESET_VALUE (DEFAULT_SEED)
    ) u_lfsr (
        .clk     (clk),
        .rst     (rst),
        .load_i  (w_lfsr_load),
        .seed_i  (w_seed),
        .en_i    (w_lfsr_en),
        .value_o (w_lfsr)
    );

    // ------------------------------------------------------------------
    // Datapath helpers
    // ------------------------------------------------------------------
    assign w_n_legal = (bus.num_elements_i != '0) && (bus.num_elements_i <= C_DEPTH);
    assign w_n_m1    = r_n - C_ONE;

    // Candidate swap partner: LFSR bits bounded by the all-ones mask that
    // covers i. Values above i are rejected and redrawn next cycle, which
    // keeps the draw uniform over 0..i.
    assign w_r     = BITS_PER_ELEMENT'(w_lfsr & mask_for(16'(r_i)));
    assign w_r_ext = {1'b0, w_r};

    assign w_k_idx   = r_k[BITS_PER_ELEMENT-1:0];
    assign w_i_idx   = r_i[BITS_PER_ELEMENT-1:0];
    assign w_c_idx   = r_c[BITS_PER_ELEMENT-1:0];
    assign w_rd_data = r_table[w_c_idx];

    // ------------------------------------------------------------------
    // FSM: next-state and control
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_n_nxt     = r_n;
        w_k_nxt     = r_k;
        w_i_nxt     = r_i;
        w_c_nxt     = r_c;
        w_lfsr_load = 1'b0;
        w_lfsr_en   = 1'b0;
        w_init_wr   = 1'b0;
        w_swap      = 1'b0;
        w_ack       = 1'b0;
        w_done      = 1'b0;
        w_err       = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (bus.start_i) begin
                    if (w_n_legal) begin
                        w_n_nxt     = bus.num_elements_i;
                        w_k_nxt     = '0;
                        w_lfsr_load = 1'b1;
                        w_state_nxt = ST_INIT;
                    end else begin
                        w_err = 1'b1;
                    end
                end
            end

            ST_INIT: begin
                w_init_wr = 1'b1;
                w_k_nxt   = r_k + C_ONE;
                if (r_k == w_n_m1) begin
                    w_i_nxt = w_n_m1;
                    w_c_nxt = '0;
                    // A single-element table is already "shuffled".
                    w_state_nxt = (r_n == C_ONE) ? ST_SERVE : ST_SHUFFLE;
                end
            end

            ST_SHUFFLE: begin
                // The LFSR steps on every attempt, accepted or not.
                w_lfsr_en = 1'b1;
                if (w_r_ext <= r_i) begin
                    w_swap  = 1'b1;
                    w_i_nxt = r_i - C_ONE;
                    if (r_i == C_ONE) begin
                        w_c_nxt     = '0;
                        w_state_nxt = ST_SERVE;
                    end
                end
            end

            ST_SERVE: begin
                if (bus.iter_req_i) begin
                    w_ack   = 1'b1;
                    w_c_nxt = r_c + C_ONE;
                    if (r_c == w_n_m1) begin
                        // An abort arriving with the final request still
                        // gets its ack, but the run is not reported done.
                        w_done      = !bus.abort_i;
                        w_state_nxt = ST_IDLE;
                    end
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        if (bus.abort_i && (r_state != ST_IDLE)) begin
            w_state_nxt = ST_IDLE;
        end
    end

    // ------------------------------------------------------------------
    // FSM: state and counter registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_n     <= '0;
            r_k     <= '0;
            r_i     <= '0;
            r_c     <= '0;
            r_index <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_n     <= w_n_nxt;
            r_k     <= w_k_nxt;
            r_i     <= w_i_nxt;
            r_c     <= w_c_nxt;
            if (w_ack) begin
                r_index <= w_rd_data;
            end
        end
    end

    // ------------------------------------------------------------------
    // Permutation table. Contents are meaningless until INIT has run, so
    // it carries no reset. When r == i both writes store the same value.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_init_wr) begin
            r_table[w_k_idx] <= w_k_idx;
        end
        if (w_swap) begin
            r_table[w_i_idx] <= r_table[w_r];
            r_table[w_r]     <= r_table[w_i_idx];
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.iter_ack_o = w_ack;
    assign bus.index_o    = w_ack ? w_rd_data : r_index;
    assign bus.ready_o    = (r_state == ST_SERVE);
    assign bus.busy_o     = (r_state == ST_INIT) || (r_state == ST_SHUFFLE);
    assign bus.done_o     = w_done;
    assign bus.err_o      = w_err;

endmodule
`default_nettype wire
